// File: rtl/p07_quad_pkg.sv
// Shared types and helpers for the quadrature encoder emitter.
//   state_t    : controller states
//   FWD / REV  : move direction encoding
//   next_phase : next (a,b) quadrature phase for a given direction
package p07_quad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

    // Forward walk: 00 -> 10 -> 11 -> 01 -> 00  (phase = {a,b})
    function automatic logic [1:0] next_phase_fwd(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    // Reverse walk: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] next_phase_rev(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
        return (dir == FWD) ? next_phase_fwd(ph) : next_phase_rev(ph);
    endfunction

endpackage

// File: rtl/p07_quad_timer.sv
// Hold timer for the quadrature emitter. Down-counter reloaded with
// HOLD_CYCLES-1; expire is asserted while enabled and the count is zero,
// so a load on every expire gives one expire strobe every HOLD_CYCLES cycles.
//   clk, reset : clock, async active-high reset
//   load       : reload the hold period (has priority)
//   en         : count enable; expire is qualified by it
//   expire     : hold period has elapsed
module p07_quad_timer #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/p07_quad_gen.sv
// Quadrature encoder emitter. Takes an absolute target position and walks
// the enc_a/enc_b pair along the shortest path until the downstream decoder
// would read that value, holding every phase for HOLD_CYCLES cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a command
// MOVE   | emitting transitions, one per hold period
// SETTLE | final hold so the decoder registers the last edge
// DONE   | one-cycle completion pulse; a new command may be accepted
//
// Ports:
//   clk, reset  : clock, async active-high reset
//   cmd_valid   : target command offered
//   cmd_ready   : command can be accepted (= !busy)
//   cmd_target  : requested absolute position
//   enc_a/enc_b : registered quadrature outputs
//   position    : count the decoder has registered so far
//   busy        : move in progress
//   done        : one-cycle completion pulse
module p07_quad_gen
    import p07_quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    output logic             enc_a,
    output logic             enc_b,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] HALF_RANGE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       phase;
    logic             dir;
    logic             half;       // set between the two transitions of a count
    logic [WIDTH-1:0] remaining;

    logic [WIDTH-1:0] diff;
    logic             diff_fwd;
    logic [WIDTH-1:0] n_counts;
    logic             accept;
    logic             start_move;
    logic             step;
    logic             last_step;
    logic             expire;

    // Shortest path: the exact half-range tie goes forward.
    assign diff       = cmd_target - position;
    assign diff_fwd   = (diff <= HALF_RANGE);
    assign n_counts   = diff_fwd ? diff : ('0 - diff);

    assign accept     = cmd_valid && cmd_ready;
    assign start_move = accept && (diff != '0);
    assign step       = (state == MOVE) && expire;
    assign last_step  = step && half && (remaining == ONE);

    p07_quad_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (start_move || step),
        .en     (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (diff == '0) ? DONE : MOVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MOVE: begin
                if (last_step) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (expire) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b1;
        case (state)
            MOVE, SETTLE: begin
                busy      = 1'b1;
                cmd_ready = 1'b0;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The phase is deliberately kept across commands; a move always starts
    // from a rest phase (00 or 11) because it only ends after a full count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= 2'b00;
            position  <= '0;
            remaining <= '0;
            dir       <= FWD;
            half      <= 1'b0;
        end else if (start_move) begin
            remaining <= n_counts;
            dir       <= diff_fwd ? FWD : REV;
            half      <= 1'b0;
        end else if (step) begin
            phase <= next_phase(phase, dir);
            half  <= ~half;
            if (!half) begin
                // First transition of a count is the decoder's counting edge.
                position <= (dir == FWD) ? position + ONE : position - ONE;
            end else begin
                remaining <= remaining - ONE;
            end
        end
    end

    assign enc_a = phase[1];
    assign enc_b = phase[0];

endmodule

// File: tb/tb_p07_quad_gen.sv
// Self-checking bench for p07_quad_gen (WIDTH=8, HOLD_CYCLES=4).
// Expected outputs come from a cycle-indexed model: after a command accepted
// at edge T0, the state at T0+c is computed from the number of transitions
// elapsed, a rotation index into the forward phase cycle, and the rule that
// position moves on the first transition of each count. A small behavioural
// quadrature decoder watches the outputs and must agree with the target.
module tb_p07_quad_gen;

    localparam int W = 8;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_target = '0;
    logic         enc_a;
    logic         enc_b;
    logic [W-1:0] position;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Model state: position and index into the forward phase cycle.
    logic [W-1:0] m_pos = '0;
    int           m_idx = 0;
    logic [1:0]   pat [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Behavioural decoder: counts on leaving a rest phase.
    logic [1:0]   dec_prev;
    logic [W-1:0] dec_cnt;

    always #5 clk = ~clk;

    p07_quad_gen #(
        .WIDTH       (W),
        .HOLD_CYCLES (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_prev <= 2'b00;
            dec_cnt  <= '0;
        end else begin
            dec_prev <= {enc_a, enc_b};
            if ((dec_prev == 2'b00 && {enc_a, enc_b} == 2'b10) ||
                (dec_prev == 2'b11 && {enc_a, enc_b} == 2'b01))
                dec_cnt <= dec_cnt + 1'b1;
            else if ((dec_prev == 2'b00 && {enc_a, enc_b} == 2'b01) ||
                     (dec_prev == 2'b11 && {enc_a, enc_b} == 2'b10))
                dec_cnt <= dec_cnt - 1'b1;
        end
    end

    // Issue (or take over an already-driven) command and check every cycle
    // through its done pulse. inject_at: cycle at which a target-9 command is
    // offered while busy. chain: offer chain_tgt in the done cycle.
    task automatic run_move(input logic [W-1:0] tgt, input bit pre_driven,
                            input int inject_at, input bit chain,
                            input logic [W-1:0] chain_tgt);
        int           d, nc, last, trans, eidx;
        bit           fwd, exp_busy, exp_done;
        logic [W-1:0] exp_pos;
        logic [1:0]   prev, cur;
        if (!pre_driven) begin
            @(negedge clk);
            cmd_valid  = 1'b1;
            cmd_target = tgt;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        d    = (int'(tgt) - int'(m_pos) + 256) % 256;
        fwd  = (d <= 128);
        nc   = fwd ? d : 256 - d;
        last = (nc == 0) ? 0 : (2 * nc + 1) * H;
        prev = pat[m_idx];
        eidx = m_idx;
        for (int c = 0; c <= last; c++) begin
            trans    = (c / H < 2 * nc) ? c / H : 2 * nc;
            eidx     = fwd ? (m_idx + trans) % 4 : (((m_idx - trans) % 4) + 4) % 4;
            exp_pos  = fwd ? m_pos + W'((trans + 1) / 2) : m_pos - W'((trans + 1) / 2);
            exp_busy = (nc != 0) && (c < last);
            exp_done = (c == last);
            cur      = {enc_a, enc_b};
            checks++;
            if (cur !== pat[eidx]) begin
                errors++;
                $display("FAIL phase tgt=%h c=%0d got %b exp %b", tgt, c, cur, pat[eidx]);
            end
            checks++;
            if (position !== exp_pos) begin
                errors++;
                $display("FAIL position tgt=%h c=%0d got %h exp %h", tgt, c, position, exp_pos);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done tgt=%h c=%0d got %b exp %b", tgt, c, done, exp_done);
            end
            if (c >= 1 || nc == 0) begin
                checks++;
                if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
                    errors++;
                    $display("FAIL busy_ready tgt=%h c=%0d got %b/%b exp %b/%b",
                             tgt, c, busy, cmd_ready, exp_busy, !exp_busy);
                end
            end
            checks++;
            if ((cur ^ prev) == 2'b11) begin
                errors++;
                $display("FAIL gray tgt=%h c=%0d got %b after %b", tgt, c, cur, prev);
            end
            prev = cur;
            if (c == last) begin
                checks++;
                if (dec_cnt !== tgt) begin
                    errors++;
                    $display("FAIL loopback tgt=%h got %h exp %h", tgt, dec_cnt, tgt);
                end
            end
            if (c == inject_at) begin
                cmd_valid  = 1'b1;
                cmd_target = 8'd9;
            end else if (c == inject_at + 1) begin
                cmd_valid = 1'b0;
            end
            if (c == last) begin
                if (chain) begin
                    cmd_valid  = 1'b1;
                    cmd_target = chain_tgt;
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        m_pos = tgt;
        m_idx = eidx;
        if (!chain) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_done tgt=%h got done=%b ready=%b exp 0/1", tgt, done, cmd_ready);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({enc_a, enc_b, position, busy, done, cmd_ready} !== {2'b00, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL reset_values got ab=%b pos=%h b/d/r=%b%b%b exp 00/00/001",
                     {enc_a, enc_b}, position, busy, done, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        // Start a move to 5 and abort it after two transitions.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 8'd5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || position !== 8'd1 || {enc_a, enc_b} !== 2'b11) begin
            errors++;
            $display("FAIL pre_abort got busy=%b pos=%h ab=%b exp 1/01/11",
                     busy, position, {enc_a, enc_b});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({enc_a, enc_b, position, busy, done, cmd_ready} !== {2'b00, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL async_reset got ab=%b pos=%h b/d/r=%b%b%b exp 00/00/001",
                     {enc_a, enc_b}, position, busy, done, cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done cycle=%0d got %b exp 0", i, done);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        m_pos = '0;
        m_idx = 0;
    endtask

    task automatic test_forward();
        run_move(8'd3, 1'b0, -1, 1'b0, 8'd0);
    endtask

    task automatic test_reverse_wrap();
        run_move(8'd0, 1'b0, -1, 1'b0, 8'd0);
        run_move(8'hFE, 1'b0, -1, 1'b0, 8'd0);
    endtask

    task automatic test_half_range();
        run_move(8'd0, 1'b0, -1, 1'b0, 8'd0);
        run_move(8'h80, 1'b0, -1, 1'b0, 8'd0);
        run_move(8'h80, 1'b0, -1, 1'b0, 8'd0);
    endtask

    task automatic test_handshake();
        run_move(8'h84, 1'b0, 5, 1'b0, 8'd0);
        run_move(8'h82, 1'b0, -1, 1'b1, 8'h86);
        run_move(8'h86, 1'b1, -1, 1'b1, 8'h86);
        run_move(8'h86, 1'b1, -1, 1'b0, 8'd0);
    endtask

    task automatic test_loopback();
        run_move(8'd10, 1'b0, -1, 1'b0, 8'd0);
        run_move(8'd250, 1'b0, -1, 1'b0, 8'd0);
        run_move(8'd7, 1'b0, -1, 1'b0, 8'd0);
    endtask

    task automatic test_random();
        logic [W-1:0] tg [9];
        bit           ch [9];
        bit           pre;
        tg[0] = m_pos;
        for (int i = 1; i < 9; i++) begin
            if ($urandom_range(0, 3) == 0)
                tg[i] = tg[i-1];
            else
                tg[i] = W'($urandom_range(0, 255));
            ch[i] = ($urandom_range(0, 1) == 1) && (i < 8);
        end
        ch[0] = 1'b0;
        pre = 1'b0;
        for (int i = 1; i < 9; i++) begin
            run_move(tg[i], pre, (i % 3 == 0) ? 2 : -1, ch[i], (i < 8) ? tg[i+1] : 8'd0);
            pre = ch[i];
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_half_range();
        test_handshake();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
